cond_flag_bank: RTL and testbench
=================================

# cond_flag_bank

Condition-flag store and issue stage directly upstream of the MCU's 4-bit flag selector. It holds 16 sticky condition flags, fed by synchronised external event lines and by a command port. On a TEST command it presents a registered `op` (flag index) and a `mayout` snapshot to the selector, with a valid/ready handshake. It optionally clears the tested flag (read-to-clear) so the sequencer can poll events without losing any.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `ev_in`; legal values 2–3.
- `NFLAG`, default 16: flag count; only 16 is supported because it must match the selector width.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ev_in` in 16: asynchronous event lines; a rising edge sets the corresponding flag.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready` at a clock edge.
- `cmd_type` in 2: `00` LOAD, `01` SET, `10` CLR, `11` TEST.
- `cmd_idx` in 4: flag index for SET, CLR and TEST.
- `cmd_data` in 16: LOAD value; for TEST, bit 0 = read-to-clear (`rtc`).
- `op` out 4: selector index, registered.
- `mayout` out 16: flag snapshot to the selector, registered.
- `sel_valid` out 1: `op`/`mayout` are valid.
- `sel_ready` in 1: selector/consumer takes the current issue.
- `flags` out 16: live flag register.

## Operation
- **Event path**: `ev_in` → `SYNC_STAGES` flops → edge register; `rise = sync_last & ~ev_q`.
- **Flag update each cycle**: `flags_next = cmd_effect(flags) | rise`. Event sets always win.
  - CLR or read-to-clear of bit i in the same cycle as `rise[i]` leaves bit i = 1.
  - LOAD yields `cmd_data | rise`.
- **Command effects**, applied only on accept:
  - LOAD: `flags <= cmd_data`.
  - SET: `flags[idx] <= 1`.
  - CLR: `flags[idx] <= 0`.
  - TEST: `op <= idx`, `mayout <= flags` (pre-update value). If `rtc`, `flags[idx] <= 0`, subject to the event-wins rule.
- **Ready**: `cmd_ready = ~sel_valid | sel_ready`, for all command types, to preserve ordering.
- **FSM**, two states (`sel_valid` = `state == HOLD`):
  - IDLE → HOLD on TEST accept.
  - HOLD → IDLE on `sel_ready` with no TEST accepted.
  - HOLD → HOLD on `sel_ready` with a TEST accepted (back-to-back issue; `op`/`mayout` reload).
  - HOLD with `~sel_ready`: `op`, `mayout` and `sel_valid` held stable; no command accepted.
- A non-TEST command accepted in HOLD with `sel_ready` updates `flags` only, and the state returns to IDLE.
- **Outputs never X**: the selector's out-of-range default is never exercised because `op` is always registered from a 4-bit index.

## Timing
- **Reset values**: `flags`, `mayout`, `op` = 0; `sel_valid` = 0; state IDLE; sync and `ev_q` registers = 0. `cmd_ready` = 1 immediately after reset.
- An `ev_in` line held high across reset release is captured as one rising edge.
- **Event latency**: `ev_in` first sampled high at edge k → `flags[i]` = 1 after edge k+`SYNC_STAGES`+1 (edge k+3 for the default).
- Pulses shorter than one clock may be missed; events must be held at least 2 cycles.
- **TEST latency**: accepted at edge N → `sel_valid`/`op`/`mayout` valid after edge N; with `rtc`, the flag clears at the same edge N.
- **Throughput**: one TEST per cycle with `sel_ready` held high.
- **Reset mid-operation**: `sel_valid` drops asynchronously and the pending issue is discarded; there is no replay.

## Structure
- Package `cond_flag_pkg` holds:
  - command codes `CMD_LOAD`, `CMD_SET`, `CMD_CLR`, `CMD_TEST`;
  - state encoding `ST_IDLE`, `ST_HOLD`;
  - constant `NFLAG` = 16.
- Sub-module `ev_sync_edge`: a per-bit `SYNC_STAGES` synchroniser plus rising-edge detector, outputting a 16-bit `rise`.
- The downstream 4-bit selector is instantiated by the parent, not inside this block.

## Test plan
- **Reset/idle**: reset, then LOAD `16'hA5C3` → `flags` = A5C3 next cycle. TEST idx 5 → `op` = 5, `mayout` = A5C3, `sel_valid` = 1, and the selector output = 0.
- **Event latency**: raise `ev_in[9]` and hold → `flags[9]` = 1 exactly 3 edges after the first sampling edge. It is not set again while held high.
- **Event-wins collision**: `flags[3]` = 1; issue CLR idx 3 in the cycle `rise[3]` is asserted → `flags[3]` stays 1. Repeat with TEST `rtc` → `mayout[3]` = 1 and `flags[3]` = 1.
- **Backpressure**: TEST idx 2 with `sel_ready` = 0 for 4 cycles → `cmd_ready` = 0, and `op`/`mayout` are stable throughout. Then `sel_ready` = 1 with a TEST idx 7 offered → back-to-back issue with `op` = 7.
- **Read-to-clear sweep**: `flags` = FFFF; TEST idx 0..15 with `rtc`, `sel_ready` = 1 → 16 issues in 16 cycles, `mayout` showing successive clears, and final `flags` = 0000.
- **Mid-issue reset**: assert `rst_n` low while in HOLD → `sel_valid` drops without waiting for a clock edge, all outputs return to reset values, and `cmd_ready` = 1 after release.

Source files
------------

// File: rtl/cond_flag_pkg.sv
// Shared definitions for the condition-flag bank.
//   NFLAG      - number of condition flags (fixed by the downstream selector width)
//   cmd_e      - command codes carried on cmd_type
//   state_e    - issue-stage state encoding
//   flag_mask  - one-hot mask for a 4-bit flag index
package cond_flag_pkg;

    localparam int unsigned NFLAG = 16;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_SET  = 2'b01,
        CMD_CLR  = 2'b10,
        CMD_TEST = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic [NFLAG-1:0] flag_mask(input logic [3:0] idx);
        logic [NFLAG-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ev_sync_edge.sv
// Synchroniser plus rising-edge detector for the asynchronous event lines.
//   clk, rst_n - clock, asynchronous active-low reset
//   ev_in      - asynchronous event lines
//   rise       - registered one-cycle pulse per line on each synchronised rising edge
module ev_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ev_in,
    output logic [WIDTH-1:0] rise
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  ev_q;
    logic [WIDTH-1:0]                  rise_q;
    logic [WIDTH-1:0]                  sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // The edge register and the rise pulse are both flopped, so a line first
    // sampled at edge k lands in the flags at edge k + SYNC_STAGES + 1. Because
    // everything resets to 0, a line held high across reset release is seen
    // as exactly one rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            ev_q   <= '0;
            rise_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ev_in};
            ev_q   <= sync_last;
            rise_q <= sync_last & ~ev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/cond_flag_bank.sv
// Sticky condition-flag store with a TEST issue stage toward the 4-bit flag selector.
//   clk, rst_n             - clock, asynchronous active-low reset
//   ev_in                  - asynchronous event lines; rising edge sets the flag
//   cmd_valid/cmd_ready    - command handshake
//   cmd_type/idx/data      - LOAD/SET/CLR/TEST, flag index, LOAD value or TEST rtc (bit 0)
//   op, mayout, sel_valid  - registered issue to the selector
//   sel_ready              - selector takes the current issue
//   flags                  - live flag register
module cond_flag_bank
    import cond_flag_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,  // 2..3
    parameter int unsigned NFLAG       = 16  // must stay 16 to match the selector
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NFLAG-1:0] ev_in,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [3:0]       cmd_idx,
    input  logic [NFLAG-1:0] cmd_data,
    output logic [3:0]       op,
    output logic [NFLAG-1:0] mayout,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic [NFLAG-1:0] flags
);

    logic [NFLAG-1:0] rise;
    logic [NFLAG-1:0] flags_q, flags_d;
    logic [NFLAG-1:0] mayout_q;
    logic [3:0]       op_q;
    state_e           state_q, state_d;
    logic             accept;
    logic             test_acc;
    logic [NFLAG-1:0] idx_mask;

    ev_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (NFLAG)
    ) u_ev_sync_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .ev_in(ev_in),
        .rise (rise)
    );

    // All command types stall while an issue is held, keeping commands ordered
    // behind an outstanding TEST.
    assign cmd_ready = (state_q == ST_IDLE) | sel_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign test_acc  = accept & (cmd_e'(cmd_type) == CMD_TEST);
    assign idx_mask  = flag_mask(cmd_idx);

    always_comb begin
        flags_d = flags_q;
        if (accept) begin
            unique case (cmd_e'(cmd_type))
                CMD_LOAD: flags_d = cmd_data;
                CMD_SET:  flags_d = flags_q | idx_mask;
                CMD_CLR:  flags_d = flags_q & ~idx_mask;
                CMD_TEST: flags_d = cmd_data[0] ? (flags_q & ~idx_mask) : flags_q;
                default:  flags_d = flags_q;
            endcase
        end
        // Events are ORed in last so they beat any clear in the same cycle.
        flags_d = flags_d | rise;
    end

    always_comb begin
        state_d = state_q;
        if (test_acc) begin
            state_d = ST_HOLD;
        end else if (sel_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            flags_q  <= '0;
            mayout_q <= '0;
            op_q     <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (test_acc) begin
                op_q     <= cmd_idx;
                mayout_q <= flags_q;  // pre-update snapshot
            end
        end
    end

    assign sel_valid = (state_q == ST_HOLD);
    assign op        = op_q;
    assign mayout    = mayout_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_cond_flag_bank.sv
module tb_cond_flag_bank;

    localparam int SYNC = 2;
    localparam int D    = SYNC + 1;  // ev_in sample edge -> flag set edge

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ev_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_idx;
    logic [15:0] cmd_data;
    logic [3:0]  op;
    logic [15:0] mayout;
    logic        sel_valid;
    logic        sel_ready;
    logic [15:0] flags;

    cond_flag_bank #(
        .SYNC_STAGES(SYNC),
        .NFLAG      (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_in    (ev_in),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type (cmd_type),
        .cmd_idx  (cmd_idx),
        .cmd_data (cmd_data),
        .op       (op),
        .mayout   (mayout),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: flags as a plain integer, events as a history of samples.
    logic [15:0] m_flags, m_may;
    logic [3:0]  m_op;
    logic        m_valid;
    logic [15:0] evh[$];

    task automatic model_reset();
        m_flags = 16'h0;
        m_may   = 16'h0;
        m_op    = 4'h0;
        m_valid = 1'b0;
        evh.delete();
        for (int i = 0; i < D + 1; i++) evh.push_back(16'h0);
    endtask

    // One clock with the given command; checks ready before the edge and all
    // registered outputs after it.
    task automatic step(input logic v, input logic [1:0] t, input logic [3:0] idx,
                        input logic [15:0] data, input logic sr);
        logic        acc;
        logic [15:0] rise, nf;
        cmd_valid = v;
        cmd_type  = t;
        cmd_idx   = idx;
        cmd_data  = data;
        sel_ready = sr;
        #1;
        check_eq("cmd_ready", cmd_ready, !m_valid || sr);
        @(posedge clk);
        acc = v && (!m_valid || sr);
        evh.push_back(ev_in);
        rise = evh[1] & ~evh[0];  // sampled high D edges ago, low D+1 edges ago
        void'(evh.pop_front());
        nf = m_flags;
        if (acc) begin
            case (t)
                2'd0: nf = data;
                2'd1: nf[idx] = 1'b1;
                2'd2: nf[idx] = 1'b0;
                default: begin
                    if (data[0]) nf[idx] = 1'b0;
                    m_op  = idx;
                    m_may = m_flags;
                end
            endcase
        end
        if (acc && t == 2'd3) m_valid = 1'b1;
        else if (sr)          m_valid = 1'b0;
        m_flags = nf | rise;
        #1;
        check_eq("flags", flags, m_flags);
        check_eq("op", op, m_op);
        check_eq("mayout", mayout, m_may);
        check_eq("sel_valid", sel_valid, m_valid);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, 16'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_sel_valid", sel_valid, 1'b0);
        check_eq("rst_flags", flags, 16'h0);
        check_eq("rst_op", op, 4'h0);
        check_eq("rst_mayout", mayout, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ev_in     = '0;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_idx   = 4'd0;
        cmd_data  = '0;
        sel_ready = 1'b0;
        model_reset();
        #12;
        do_reset();
        check_eq("ready_after_reset", cmd_ready, 1'b1);

        // Load and first issue; selector output is the flag picked by op.
        step(1'b1, 2'd0, 4'd0, 16'hA5C3, 1'b0);
        check_eq("load_a5c3", flags, 16'hA5C3);
        step(1'b1, 2'd3, 4'd5, 16'h0, 1'b0);
        check_eq("test_op", op, 4'd5);
        check_eq("test_mayout", mayout, 16'hA5C3);
        check_eq("test_valid", sel_valid, 1'b1);
        check_eq("sel_out", mayout[op], 1'b0);
        idle(2);

        // Event latency on line 9.
        step(1'b1, 2'd2, 4'd9, 16'h0, 1'b1);
        ev_in[9] = 1'b1;
        idle(3);
        check_eq("ev9_early", flags[9], 1'b0);
        idle(1);
        check_eq("ev9_set", flags[9], 1'b1);
        step(1'b1, 2'd2, 4'd9, 16'h0, 1'b1);
        idle(5);
        check_eq("ev9_held", flags[9], 1'b0);
        ev_in[9] = 1'b0;

        // Event beats CLR and read-to-clear in the same cycle.
        step(1'b1, 2'd1, 4'd3, 16'h0, 1'b1);
        ev_in[3] = 1'b1;
        idle(3);
        step(1'b1, 2'd2, 4'd3, 16'h0, 1'b1);
        check_eq("collide_clr", flags[3], 1'b1);
        ev_in[3] = 1'b0;
        idle(2);
        ev_in[3] = 1'b1;
        idle(3);
        step(1'b1, 2'd3, 4'd3, 16'h1, 1'b1);
        check_eq("collide_rtc_may", mayout[3], 1'b1);
        check_eq("collide_rtc_flag", flags[3], 1'b1);
        ev_in[3] = 1'b0;
        idle(3);

        // Backpressure then back-to-back issue.
        step(1'b1, 2'd3, 4'd2, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd3, 4'd9, 16'h1, 1'b0);
            check_eq("bp_op", op, 4'd2);
        end
        step(1'b1, 2'd3, 4'd7, 16'h0, 1'b1);
        check_eq("b2b_op", op, 4'd7);
        check_eq("b2b_valid", sel_valid, 1'b1);
        idle(2);

        // Read-to-clear sweep.
        step(1'b1, 2'd0, 4'd0, 16'hFFFF, 1'b1);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] exp_may;
            exp_may = 16'hFFFF << i;
            step(1'b1, 2'd3, 4'(i), 16'h1, 1'b1);
            check_eq("sweep_may", mayout, exp_may);
            check_eq("sweep_valid", sel_valid, 1'b1);
        end
        check_eq("sweep_final", flags, 16'h0);

        // Reset while holding an issue; line 12 held across release.
        step(1'b1, 2'd3, 4'd4, 16'h0, 1'b0);
        ev_in[12] = 1'b1;
        do_reset();
        check_eq("ready_after_midreset", cmd_ready, 1'b1);
        idle(4);
        check_eq("ev_across_reset", flags[12], 1'b1);
        ev_in[12] = 1'b0;

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) ev_in[$urandom_range(15)] ^= 1'b1;
            step($urandom_range(3) != 0, 2'($urandom_range(3)), 4'($urandom_range(15)),
                 16'($urandom), $urandom_range(2) != 0);
            if (c == 700) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
